// File: rtl/tt_ctrl_seq.sv
// Sequencer that turns "select design N, enable/disable" into the reset / increment-pulse / enable
// sequence for a ripple-counter based mux controller, tracking the counter value in cur_addr.
module tt_ctrl_seq #(
    parameter int ADDR_W     = 10,
    parameter int RST_CYC    = 4,
    parameter int HI_CYC     = 2,
    parameter int LO_CYC     = 2,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    if (RST_CYC < 1 || RST_CYC > 255 || HI_CYC < 1 || HI_CYC > 255 ||
        LO_CYC < 1 || LO_CYC > 255 || SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_param_check
        $error("tt_ctrl_seq: cycle-count parameters must lie in 1..255");
    end

    localparam logic [7:0] RST_LAST    = 8'(RST_CYC - 1);
    localparam logic [7:0] HI_LAST     = 8'(HI_CYC - 1);
    localparam logic [7:0] LO_LAST     = 8'(LO_CYC - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DIS, S_RST, S_REC, S_PHI, S_PLO, S_SETTLE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              ena_lat_q, ena_lat_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic              sel_rst_n_q, sel_rst_n_d;
    logic              sel_inc_q, sel_inc_d;
    logic              ena_q, ena_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 8'd1;
        target_d  = target_q;
        ena_lat_d = ena_lat_q;
        rem_d     = rem_q;
        cur_d     = cur_q;
        ena_d     = ena_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (req_valid) begin
                    target_d  = req_addr;
                    ena_lat_d = req_ena;
                    ena_d     = 1'b0;
                    state_d   = S_DIS;
                end
            end
            S_DIS: begin
                cnt_d = 8'd0;
                if (target_q == cur_q) begin
                    state_d = S_SETTLE;
                end else if (target_q > cur_q) begin
                    rem_d   = target_q - cur_q;
                    state_d = S_PHI;
                end else begin
                    state_d = S_RST;
                end
            end
            S_RST: begin
                cur_d = '0;
                if (cnt_q == RST_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_REC;
                end
            end
            S_REC: begin
                cnt_d   = 8'd0;
                rem_d   = target_q;
                state_d = (target_q == '0) ? S_SETTLE : S_PHI;
            end
            S_PHI: begin
                if (cnt_q == HI_LAST) begin
                    cnt_d   = 8'd0;
                    cur_d   = cur_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = S_PLO;
                end
            end
            S_PLO: begin
                if (cnt_q == LO_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = (rem_q == '0) ? S_SETTLE : S_PHI;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 8'd0;
                    ena_d   = ena_lat_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
        // Controller strobes follow the upcoming state so they change together with it, glitch-free.
        sel_rst_n_d = (state_d != S_RST);
        sel_inc_d   = (state_d == S_PHI);
        ready_d     = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            target_q    <= '0;
            ena_lat_q   <= 1'b0;
            rem_q       <= '0;
            cur_q       <= '0;
            sel_rst_n_q <= 1'b0;
            sel_inc_q   <= 1'b0;
            ena_q       <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            ena_lat_q   <= ena_lat_d;
            rem_q       <= rem_d;
            cur_q       <= cur_d;
            sel_rst_n_q <= sel_rst_n_d;
            sel_inc_q   <= sel_inc_d;
            ena_q       <= ena_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign req_ready      = ready_q;
    assign busy           = ~ready_q;
    assign done           = done_q;
    assign cur_addr       = cur_q;
    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign ctrl_sel_inc   = sel_inc_q;
    assign ctrl_ena       = ena_q;

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Directed bench for tt_ctrl_seq with a behavioural model of the controller's ripple counter.
module tb_tt_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [9:0] req_addr = '0;
    logic       req_ena = 1'b0;
    logic       busy;
    logic       done;
    logic [9:0] cur_addr;
    logic       ctrl_sel_rst_n;
    logic       ctrl_sel_inc;
    logic       ctrl_ena;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int inc_cnt = 0;
    int rst_cyc_cnt = 0;
    int both_cnt = 0;
    int ena_busy_cnt = 0;
    logic [9:0] model = '0;

    tt_ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_ena(req_ena), .busy(busy), .done(done),
        .cur_addr(cur_addr), .ctrl_sel_rst_n(ctrl_sel_rst_n),
        .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ripple counter of the controller: async clear, increments on inc rising edge.
    always @(posedge ctrl_sel_inc or negedge ctrl_sel_rst_n) begin
        if (!ctrl_sel_rst_n) model <= '0;
        else                 model <= model + 10'd1;
    end

    always @(posedge ctrl_sel_inc) inc_cnt <= inc_cnt + 1;

    always @(negedge clk) begin
        if (rst_n && ctrl_sel_rst_n === 1'b0) rst_cyc_cnt <= rst_cyc_cnt + 1;
        if (ctrl_sel_rst_n === 1'b0 && ctrl_sel_inc === 1'b1) both_cnt <= both_cnt + 1;
        if (busy === 1'b1 && ctrl_ena === 1'b1) ena_busy_cnt <= ena_busy_cnt + 1;
    end

    // Issues one request at a negedge and waits (bounded) for done; lat = -1 on timeout.
    task automatic do_req(input logic [9:0] addr, input logic ena, input bit poke,
                          output int lat, output int pulses, output int rstc, output logic ena_dis);
        int k;
        int acc;
        int pbase;
        int rbase;
        k = 0;
        while (req_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        pbase     = inc_cnt;
        rbase     = rst_cyc_cnt;
        req_valid = 1'b1;
        req_addr  = addr;
        req_ena   = ena;
        @(negedge clk);
        acc       = cyc;
        ena_dis   = ctrl_ena;
        req_valid = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
            if (poke && k == 2) begin
                req_valid = 1'b1;
                req_addr  = 10'd9;
            end
            if (poke && k == 4) req_valid = 1'b0;
        end
        lat    = (done === 1'b1) ? (cyc - acc) : -1;
        pulses = inc_cnt - pbase;
        rstc   = rst_cyc_cnt - rbase;
        $display("req addr=%0d ena=%0d: latency=%0d pulses=%0d rst_cycles=%0d model=%0d cur_addr=%0d ctrl_ena=%0b",
                 addr, ena, lat, pulses, rstc, model, cur_addr, ctrl_ena);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: rst_n/inc/ena/done=%b required 0000",
                     {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done});
        end
        checks++;
        if (cur_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_cur_addr: got %0d required 0", cur_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_sel_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL release_sel_rst_n: got %b required 1", ctrl_sel_rst_n);
        end
        checks++;
        if ({req_ready, busy, cur_addr} !== {1'b1, 1'b0, 10'd0}) begin
            errors++;
            $display("FAIL release_idle: ready=%b busy=%b cur=%0d required 1 0 0", req_ready, busy, cur_addr);
        end
    endtask

    // Common post-request checks against hand-computed expectations.
    task automatic check_req(input string name, input int lat, input int pulses, input int rstc,
                             input logic ena_dis, input int exp_lat, input int exp_pulses,
                             input int exp_rstc, input logic [9:0] exp_addr, input logic exp_ena);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (pulses !== exp_pulses || rstc !== exp_rstc) begin
            errors++;
            $display("FAIL %s_pulses_rst: got %0d/%0d required %0d/%0d", name, pulses, rstc, exp_pulses, exp_rstc);
        end
        checks++;
        if (model !== exp_addr || cur_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_addr: model=%0d cur_addr=%0d required %0d", name, model, cur_addr, exp_addr);
        end
        checks++;
        if (ctrl_ena !== exp_ena || ena_dis !== 1'b0) begin
            errors++;
            $display("FAIL %s_ena: final=%b at_dis=%b required %b 0", name, ctrl_ena, ena_dis, exp_ena);
        end
    endtask

    task automatic test_forward();
        int lat, pulses, rstc;
        logic ena_dis;
        do_req(10'd5, 1'b1, 1'b0, lat, pulses, rstc, ena_dis);
        check_req("fwd5", lat, pulses, rstc, ena_dis, 29, 5, 0, 10'd5, 1'b1);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL fwd5_done_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_backward();
        int lat, pulses, rstc;
        logic ena_dis;
        do_req(10'd3, 1'b1, 1'b0, lat, pulses, rstc, ena_dis);
        check_req("back3", lat, pulses, rstc, ena_dis, 26, 3, 4, 10'd3, 1'b1);
    endtask

    task automatic test_same_busy_ignored();
        int lat, pulses, rstc, p0;
        logic ena_dis;
        do_req(10'd3, 1'b0, 1'b1, lat, pulses, rstc, ena_dis);
        check_req("same3", lat, pulses, rstc, ena_dis, 9, 0, 0, 10'd3, 1'b0);
        p0 = inc_cnt;
        repeat (6) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || inc_cnt !== p0 || cur_addr !== 10'd3) begin
            errors++;
            $display("FAIL busy_req_ignored: ready=%b extra_pulses=%0d cur=%0d required 1 0 3",
                     req_ready, inc_cnt - p0, cur_addr);
        end
    endtask

    task automatic test_full_range();
        int lat, pulses, rstc;
        logic ena_dis;
        do_req(10'd0, 1'b0, 1'b0, lat, pulses, rstc, ena_dis);
        check_req("zero", lat, pulses, rstc, ena_dis, 14, 0, 4, 10'd0, 1'b0);
        do_req(10'd1023, 1'b1, 1'b0, lat, pulses, rstc, ena_dis);
        check_req("max", lat, pulses, rstc, ena_dis, 4101, 1023, 0, 10'd1023, 1'b1);
    endtask

    task automatic test_reset_mid();
        int lat, pulses, rstc, k, pbase;
        logic ena_dis;
        pbase     = inc_cnt;
        req_valid = 1'b1;
        req_addr  = 10'd7;
        req_ena   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!(inc_cnt - pbase >= 3 && ctrl_sel_inc === 1'b1) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 2000) begin
            errors++;
            $display("FAIL mid_reach_phi: third pulse not seen within 2000 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ctrl_sel_inc, ctrl_ena, ctrl_sel_rst_n} !== 3'b000 || model !== 10'd0 || cur_addr !== 10'd0) begin
            errors++;
            $display("FAIL mid_async_reset: inc/ena/sel_rst_n=%b model=%0d cur=%0d required 000 0 0",
                     {ctrl_sel_inc, ctrl_ena, ctrl_sel_rst_n}, model, cur_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_sel_rst_n !== 1'b1 || req_ready !== 1'b1 || ctrl_sel_inc !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: sel_rst_n=%b ready=%b inc=%b required 1 1 0",
                     ctrl_sel_rst_n, req_ready, ctrl_sel_inc);
        end
        do_req(10'd2, 1'b1, 1'b0, lat, pulses, rstc, ena_dis);
        check_req("after_rst2", lat, pulses, rstc, ena_dis, 17, 2, 0, 10'd2, 1'b1);
        checks++;
        if (both_cnt !== 0 || ena_busy_cnt !== 0) begin
            errors++;
            $display("FAIL exclusivity: both_active_cycles=%0d ena_while_busy=%0d required 0 0",
                     both_cnt, ena_busy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_backward();
        test_same_busy_ignored();
        test_full_range();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
